// File: rtl/voice_allocator.sv
// Voice allocator: buffers one note from the song reader and dispatches it to the
// lowest-index free note player. Define VOICE_STEAL_EN to steal the oldest busy voice instead of waiting.
module voice_allocator #(
    parameter int NOTE_WIDTH     = 6,
    parameter int DURATION_WIDTH = 6,
    parameter int NUM_VOICES     = 3,
    parameter int AGE_WIDTH      = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               play,
    input  logic                               clear,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NOTE_WIDTH-1:0]              in_note,
    input  logic [DURATION_WIDTH-1:0]          in_duration,
    input  logic [NUM_VOICES-1:0]              voice_done,
    output logic [NUM_VOICES-1:0]              voice_load,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0]   voice_note,
    output logic [NUM_VOICES*DURATION_WIDTH-1:0] voice_dur,
    output logic [NUM_VOICES-1:0]              voice_busy,
    output logic [7:0]                         stall_count
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

    typedef enum logic {ST_EMPTY, ST_PEND} state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [NOTE_WIDTH-1:0]       r_pend_note;
    logic [DURATION_WIDTH-1:0]   r_pend_dur;
    logic [7:0]                  r_stall;

    logic                        w_accept;
    logic                        w_dispatch;
    logic                        w_blocked;
    logic                        w_free_any;
    logic [IDX_W-1:0]            w_free_idx;
    logic [IDX_W-1:0]            w_disp_idx;

    assign in_ready    = (r_state == ST_EMPTY);
    assign stall_count = r_stall;
    assign w_free_any  = ~(&voice_busy);

    // Descending scan so the lowest-index free voice is the one left standing.
    always_comb begin
        w_free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!voice_busy[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [NUM_VOICES*AGE_WIDTH-1:0] w_age_flat;
    logic [IDX_W-1:0]                w_old_idx;
    logic [AGE_WIDTH-1:0]            w_old_age;

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        w_old_idx = '0;
        w_old_age = w_age_flat[AGE_WIDTH-1:0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (w_age_flat[i*AGE_WIDTH +: AGE_WIDTH] > w_old_age) begin
                w_old_age = w_age_flat[i*AGE_WIDTH +: AGE_WIDTH];
                w_old_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_dispatch   = 1'b0;
        w_blocked    = 1'b0;
        w_disp_idx   = w_free_idx;
        case (r_state)
            ST_EMPTY: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (play) begin
                    if (w_free_any) begin
                        w_dispatch   = 1'b1;
                        w_state_next = ST_EMPTY;
                    end else begin
`ifdef VOICE_STEAL_EN
                        w_dispatch   = 1'b1;
                        w_disp_idx   = w_old_idx;
                        w_state_next = ST_EMPTY;
`else
                        w_blocked    = 1'b1;
`endif
                    end
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_pend_note <= '0;
            r_pend_dur  <= '0;
            r_stall     <= '0;
        end else if (clear) begin
            r_state     <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_pend_note <= in_note;
                r_pend_dur  <= in_duration;
            end
            if (w_blocked && (r_stall != 8'hFF)) begin
                r_stall <= r_stall + 8'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic                      w_hit;
            logic                      r_load;
            logic                      r_busy;
            logic [AGE_WIDTH-1:0]      r_age;
            logic [NOTE_WIDTH-1:0]     r_note;
            logic [DURATION_WIDTH-1:0] r_dur;

            assign w_hit = w_dispatch && (w_disp_idx == IDX_W'(gi));

            // A dispatch outranks a simultaneous done, so a stolen voice stays busy.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_load <= 1'b0;
                    r_busy <= 1'b0;
                    r_age  <= '0;
                    r_note <= '0;
                    r_dur  <= '0;
                end else if (clear) begin
                    r_load <= 1'b0;
                    r_busy <= 1'b0;
                    r_age  <= '0;
                end else begin
                    r_load <= w_hit;
                    if (w_hit) begin
                        r_busy <= 1'b1;
                        r_age  <= '0;
                        r_note <= r_pend_note;
                        r_dur  <= r_pend_dur;
                    end else if (voice_done[gi] && r_busy) begin
                        r_busy <= 1'b0;
                        r_age  <= '0;
                    end else if (play && r_busy && (r_age != AGE_MAX)) begin
                        r_age  <= r_age + 1'b1;
                    end
                end
            end

            assign voice_load[gi] = r_load;
            assign voice_busy[gi] = r_busy;
            assign voice_note[gi*NOTE_WIDTH +: NOTE_WIDTH]         = r_note;
            assign voice_dur[gi*DURATION_WIDTH +: DURATION_WIDTH]  = r_dur;
`ifdef VOICE_STEAL_EN
            assign w_age_flat[gi*AGE_WIDTH +: AGE_WIDTH] = r_age;
`endif
        end
    endgenerate

endmodule
